// File: rtl/snow64_memory_bus_guard.sv
// rtl/snow64_memory_bus_guard.sv - round-robin guard for the external memory bus
// Serves one read-FIFO or write-FIFO command at a time; every output is registered.
module snow64_memory_bus_guard #(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 256,
  parameter int LINE_BYTES_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_cmd_accepted,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_cmd_accepted,
  output logic                  wr_valid,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUS_RD = 2'd1,
    ST_BUS_WR = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << LINE_BYTES_LOG2) - ADDR_WIDTH'(1));

  localparam logic GRANT_READ  = 1'b0;
  localparam logic GRANT_WRITE = 1'b1;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  rd_cmd_accepted_q, rd_cmd_accepted_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  wr_cmd_accepted_q, wr_cmd_accepted_d;
  logic                  wr_valid_q, wr_valid_d;
  logic                  grant_rd;
  logic                  grant_wr;

  always_comb begin
    state_d           = state_q;
    last_grant_d      = last_grant_q;
    mem_req_d         = mem_req_q;
    mem_we_d          = mem_we_q;
    mem_addr_d        = mem_addr_q;
    mem_wdata_d       = mem_wdata_q;
    rd_data_d         = rd_data_q;
    rd_cmd_accepted_d = 1'b0;
    rd_valid_d        = 1'b0;
    wr_cmd_accepted_d = 1'b0;
    wr_valid_d        = 1'b0;
    // On a tie, the requester that did not win last time goes first.
    grant_rd = rd_req && (!wr_req || (last_grant_q == GRANT_WRITE));
    grant_wr = wr_req && !grant_rd;

    case (state_q)
      ST_IDLE: begin
        if (grant_rd) begin
          state_d           = ST_BUS_RD;
          last_grant_d      = GRANT_READ;
          rd_cmd_accepted_d = 1'b1;
          mem_req_d         = 1'b1;
          mem_we_d          = 1'b0;
          mem_addr_d        = rd_addr & LINE_MASK;
        end else if (grant_wr) begin
          state_d           = ST_BUS_WR;
          last_grant_d      = GRANT_WRITE;
          wr_cmd_accepted_d = 1'b1;
          mem_req_d         = 1'b1;
          mem_we_d          = 1'b1;
          mem_addr_d        = wr_addr & LINE_MASK;
          mem_wdata_d       = wr_data;
        end else begin
          mem_req_d = 1'b0;
        end
      end
      ST_BUS_RD: begin
        if (mem_ack) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          rd_valid_d = 1'b1;
          rd_data_d  = mem_rdata;
        end
      end
      ST_BUS_WR: begin
        if (mem_ack) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          wr_valid_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      last_grant_q      <= GRANT_WRITE;
      mem_req_q         <= 1'b0;
      mem_we_q          <= 1'b0;
      mem_addr_q        <= '0;
      mem_wdata_q       <= '0;
      rd_cmd_accepted_q <= 1'b0;
      rd_valid_q        <= 1'b0;
      rd_data_q         <= '0;
      wr_cmd_accepted_q <= 1'b0;
      wr_valid_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      last_grant_q      <= last_grant_d;
      mem_req_q         <= mem_req_d;
      mem_we_q          <= mem_we_d;
      mem_addr_q        <= mem_addr_d;
      mem_wdata_q       <= mem_wdata_d;
      rd_cmd_accepted_q <= rd_cmd_accepted_d;
      rd_valid_q        <= rd_valid_d;
      rd_data_q         <= rd_data_d;
      wr_cmd_accepted_q <= wr_cmd_accepted_d;
      wr_valid_q        <= wr_valid_d;
    end
  end

  assign rd_cmd_accepted = rd_cmd_accepted_q;
  assign rd_valid        = rd_valid_q;
  assign rd_data         = rd_data_q;
  assign wr_cmd_accepted = wr_cmd_accepted_q;
  assign wr_valid        = wr_valid_q;
  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_snow64_memory_bus_guard.sv
// tb/tb_snow64_memory_bus_guard.sv - directed vector bench for snow64_memory_bus_guard
// Data lines are built from one repeated byte so vectors stay compact.
module tb_snow64_memory_bus_guard;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_req;
  logic [63:0]  rd_addr;
  logic         rd_cmd_accepted;
  logic         rd_valid;
  logic [255:0] rd_data;
  logic         wr_req;
  logic [63:0]  wr_addr;
  logic [255:0] wr_data;
  logic         wr_cmd_accepted;
  logic         wr_valid;
  logic         mem_req;
  logic         mem_we;
  logic [63:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic         mem_ack;
  logic [255:0] mem_rdata;

  snow64_memory_bus_guard #(
    .ADDR_WIDTH(64),
    .DATA_WIDTH(256),
    .LINE_BYTES_LOG2(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_cmd_accepted(rd_cmd_accepted),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_cmd_accepted(wr_cmd_accepted),
    .wr_valid(wr_valid),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rr;
    logic [63:0] ra;
    logic        wr;
    logic [63:0] wa;
    logic [7:0]  wd;
    logic        ack;
    logic [7:0]  rdat;
    logic        e_racc;
    logic        e_rv;
    logic [7:0]  e_rd;
    logic        e_wacc;
    logic        e_wv;
    logic        e_mreq;
    logic        e_mwe;
    logic [63:0] e_maddr;
    logic [7:0]  e_mwd;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_miss = 0;

  function automatic logic [255:0] line(input logic [7:0] b);
    return {32{b}};
  endfunction

  task automatic add(input logic rr, input logic [63:0] ra, input logic wr, input logic [63:0] wa,
                     input logic [7:0] wd, input logic ack, input logic [7:0] rdat,
                     input logic e_racc, input logic e_rv, input logic [7:0] e_rd,
                     input logic e_wacc, input logic e_wv, input logic e_mreq, input logic e_mwe,
                     input logic [63:0] e_maddr, input logic [7:0] e_mwd);
    vec_t v;
    v.rr = rr; v.ra = ra; v.wr = wr; v.wa = wa; v.wd = wd; v.ack = ack; v.rdat = rdat;
    v.e_racc = e_racc; v.e_rv = e_rv; v.e_rd = e_rd; v.e_wacc = e_wacc; v.e_wv = e_wv;
    v.e_mreq = e_mreq; v.e_mwe = e_mwe; v.e_maddr = e_maddr; v.e_mwd = e_mwd;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [255:0] act, input logic [255:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // rr ra wr wa wd ack rdat | racc rv rd wacc wv mreq mwe maddr mwd
    add(1,'h1234,0,0,0,       0,0,     1,0,'h00,0,0,1,0,'h1220,0);
    add(0,'h1234,0,0,0,       0,0,     0,0,'h00,0,0,1,0,'h1220,0);
    add(0,0,0,0,0,            0,0,     0,0,'h00,0,0,1,0,'h1220,0);
    add(0,0,0,0,0,            1,'hAB,  0,1,'hAB,0,0,0,0,0,0);
    add(0,0,0,0,0,            0,0,     0,0,'hAB,0,0,0,0,0,0);
    add(0,0,1,'h40,'h5A,      0,0,     0,0,'hAB,1,0,1,1,'h40,'h5A);
    add(0,0,0,'h999,'h33,     0,0,     0,0,'hAB,0,0,1,1,'h40,'h5A);
    add(0,0,0,0,0,            1,'h11,  0,0,'hAB,0,1,0,0,0,0);
    add(0,0,0,0,0,            0,0,     0,0,'hAB,0,0,0,0,0,0);
    add(1,'h100,1,'h200,'h77, 0,0,     1,0,'hAB,0,0,1,0,'h100,0);
    add(0,'h100,1,'h200,'h77, 0,0,     0,0,'hAB,0,0,1,0,'h100,0);
    add(0,0,1,'h200,'h77,     1,'h01,  0,1,'h01,0,0,0,0,0,0);
    add(1,'h15F,1,'h200,'h77, 0,0,     0,0,'h01,1,0,1,1,'h200,'h77);
    add(1,'h15F,0,0,0,        1,'hEE,  0,0,'h01,0,1,0,0,0,0);
    add(1,'h15F,1,'h300,'h66, 0,0,     1,0,'h01,0,0,1,0,'h140,0);
    add(0,0,1,'h300,'h66,     1,'h02,  0,1,'h02,0,0,0,0,0,0);
    add(0,0,1,'h300,'h66,     0,0,     0,0,'h02,1,0,1,1,'h300,'h66);
    add(0,0,0,0,0,            1,'h00,  0,0,'h02,0,1,0,0,0,0);
    add(0,0,0,0,0,            1,'hCC,  0,0,'h02,0,0,0,0,0,0);
    add(0,0,0,0,0,            1,'hCC,  0,0,'h02,0,0,0,0,0,0);

    tick();
    tick();
    n_vec++;
    chk("reset_mem_req", -1, 256'(mem_req), 256'(0));
    chk("reset_mem_we", -1, 256'(mem_we), 256'(0));
    chk("reset_mem_addr", -1, 256'(mem_addr), 256'(0));
    chk("reset_mem_wdata", -1, mem_wdata, 256'(0));
    chk("reset_rd_acc", -1, 256'(rd_cmd_accepted), 256'(0));
    chk("reset_rd_valid", -1, 256'(rd_valid), 256'(0));
    chk("reset_rd_data", -1, rd_data, 256'(0));
    chk("reset_wr_acc", -1, 256'(wr_cmd_accepted), 256'(0));
    chk("reset_wr_valid", -1, 256'(wr_valid), 256'(0));
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      rd_req = vq[i].rr; rd_addr = vq[i].ra;
      wr_req = vq[i].wr; wr_addr = vq[i].wa; wr_data = line(vq[i].wd);
      mem_ack = vq[i].ack; mem_rdata = line(vq[i].rdat);
      tick();
      n_vec++;
      chk("rd_cmd_accepted", i, 256'(rd_cmd_accepted), 256'(vq[i].e_racc));
      chk("rd_valid", i, 256'(rd_valid), 256'(vq[i].e_rv));
      chk("rd_data", i, rd_data, line(vq[i].e_rd));
      chk("wr_cmd_accepted", i, 256'(wr_cmd_accepted), 256'(vq[i].e_wacc));
      chk("wr_valid", i, 256'(wr_valid), 256'(vq[i].e_wv));
      chk("mem_req", i, 256'(mem_req), 256'(vq[i].e_mreq));
      if (vq[i].e_mreq) begin
        chk("mem_we", i, 256'(mem_we), 256'(vq[i].e_mwe));
        chk("mem_addr", i, 256'(mem_addr), 256'(vq[i].e_maddr));
        if (vq[i].e_mwe) chk("mem_wdata", i, mem_wdata, line(vq[i].e_mwd));
      end
    end

    // Reset in the middle of a read: request drops without a clock edge, no valid follows.
    idle_inputs();
    rd_req = 1'b1; rd_addr = 64'h2000;
    tick();
    n_vec++;
    chk("midrst_acc", 100, 256'(rd_cmd_accepted), 256'(1));
    chk("midrst_req", 100, 256'(mem_req), 256'(1));
    rd_req = 1'b0;
    tick();
    n_vec++;
    chk("midrst_busy", 101, 256'(mem_req), 256'(1));
    rst = 1'b1;
    #1;
    n_vec++;
    chk("midrst_async_drop", 102, 256'(mem_req), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = line(8'h99);
    tick();
    n_vec++;
    chk("postrst_ack_valid", 103, 256'(rd_valid), 256'(0));
    chk("postrst_ack_data", 103, rd_data, 256'(0));
    chk("postrst_ack_req", 103, 256'(mem_req), 256'(0));
    mem_ack = 1'b0; mem_rdata = '0;
    rd_req = 1'b1; rd_addr = 64'h203F; wr_req = 1'b1; wr_addr = 64'h500; wr_data = line(8'h44);
    tick();
    n_vec++;
    chk("postrst_tie_racc", 104, 256'(rd_cmd_accepted), 256'(1));
    chk("postrst_tie_wacc", 104, 256'(wr_cmd_accepted), 256'(0));
    chk("postrst_tie_req", 104, 256'(mem_req), 256'(1));
    chk("postrst_tie_we", 104, 256'(mem_we), 256'(0));
    chk("postrst_tie_addr", 104, 256'(mem_addr), 256'(64'h2020));
    rd_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = line(8'h3C);
    tick();
    n_vec++;
    chk("postrst_rd_valid", 105, 256'(rd_valid), 256'(1));
    chk("postrst_rd_data", 105, rd_data, line(8'h3C));
    chk("postrst_no_wacc", 105, 256'(wr_cmd_accepted), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
